// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and the uart benches.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_START = 2'd1,
      WAIT_DONE  = 2'd2
   } arb_state_e;

   localparam int CNT_W     = 4;
   localparam int CLK_HZ    = 50_000_000;
   localparam int BAUD_RATE = 115_200;
   localparam int BIT_TICKS = CLK_HZ / BAUD_RATE;

   // Advance a requester index by one, wrapping at n.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart-facing signals of the arbiter, grouped as one bundle.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_send;
   logic                 tx_busy;
   logic [NUM_REQ-1:0]   grant;
   logic                 idle;

   modport slave (
      input  req_valid, req_data, req_last, tx_busy,
      output req_ready, tx_data, tx_send, grant, idle
   );

   modport master (
      output req_valid, req_data, req_last, tx_busy,
      input  req_ready, tx_data, tx_send, grant, idle
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or above ptr,
// or only the lock owner while a multi-byte message is open.
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   input  logic                       lock_i,
   input  logic [$clog2(NUM_REQ)-1:0] owner_i,
   output logic [NUM_REQ-1:0]         win_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o
);

   localparam int IDXW = $clog2(NUM_REQ);

   logic [IDXW-1:0] cand;

   // Scanning from the far end lets the nearest valid index overwrite earlier hits.
   always_comb begin
      win_o = '0;
      idx_o = '0;
      cand  = '0;
      if (lock_i) begin
         if (req_i[owner_i]) begin
            win_o[owner_i] = 1'b1;
            idx_o          = owner_i;
         end
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDXW'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[cand]) begin
               win_o       = '0;
               win_o[cand] = 1'b1;
               idx_o       = cand;
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter between NUM_REQ byte producers,
// with message locking so multi-byte messages are never interleaved.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int BUSY_TIMEOUT = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   uart_tx_arbiter_if.slave  bus
);

   localparam int IDXW = $clog2(NUM_REQ);

   arb_state_e         state_q;
   logic [IDXW-1:0]    rr_ptr_q;
   logic [IDXW-1:0]    owner_q;
   logic               lock_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [7:0]         tx_data_q;
   logic               tx_send_q;
   logic [NUM_REQ-1:0] grant_q;
   logic               idle_q;

   logic [NUM_REQ-1:0] win;
   logic [IDXW-1:0]    win_idx;
   logic               accept;
   logic [7:0]         win_data;
   logic               win_last;
   logic [CNT_W-1:0]   cnt_d;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (bus.req_valid),
      .ptr_i   (rr_ptr_q),
      .lock_i  (lock_q),
      .owner_i (owner_q),
      .win_o   (win),
      .idx_o   (win_idx)
   );

   assign accept   = !rst_i && (state_q == IDLE) && !bus.tx_busy && (win != '0);
   assign win_data = bus.req_data[{win_idx, 3'b000} +: 8];
   assign win_last = bus.req_last[win_idx];
   assign cnt_d    = cnt_q + CNT_W'(1);

   assign bus.req_ready = accept ? win : '0;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_send   = tx_send_q;
   assign bus.grant     = grant_q;
   assign bus.idle      = idle_q;

   // Grant and idle are only released when a frame ends outside an open message.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         lock_q    <= 1'b0;
         cnt_q     <= '0;
         tx_data_q <= 8'h00;
         tx_send_q <= 1'b0;
         grant_q   <= '0;
         idle_q    <= 1'b1;
      end else begin
         tx_send_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  tx_data_q <= win_data;
                  tx_send_q <= 1'b1;
                  grant_q   <= win;
                  idle_q    <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= WAIT_START;
                  if (win_last) begin
                     lock_q   <= 1'b0;
                     rr_ptr_q <= IDXW'(wrap_inc(int'(win_idx), NUM_REQ));
                  end else begin
                     lock_q  <= 1'b1;
                     owner_q <= win_idx;
                  end
               end
            end
            WAIT_START: begin
               cnt_q <= cnt_d;
               if (bus.tx_busy) begin
                  state_q <= WAIT_DONE;
               end else if (cnt_d == CNT_W'(BUSY_TIMEOUT)) begin
                  state_q <= IDLE;
                  if (!lock_q) begin
                     grant_q <= '0;
                     idle_q  <= 1'b1;
                  end
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  state_q <= IDLE;
                  if (!lock_q) begin
                     grant_q <= '0;
                     idle_q  <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message mixes
// checked against a queue-level round-robin/message model and a simple uart model.
module tb_uart_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 4;

   typedef logic [7:0] byteQ_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

   uart_tx_arbiter #(.NUM_REQ(NREQ), .BUSY_TIMEOUT(TIMEOUT)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [7:0] dq[NREQ][$];
   bit         lq[NREQ][$];
   byteQ_t     rxQ;
   int         frameLen     = 6;
   int         busyCnt      = 0;
   int         mPtr         = 0;
   bit         startPending = 1'b0;
   bit         ignoreUart   = 1'b0;
   bit         forceBusy    = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pushByte(input int i, input logic [7:0] b, input bit l);
      dq[i].push_back(b);
      lq[i].push_back(l);
   endtask

   // Requesters present the head of their queue; the uart model drives tx_busy.
   task automatic applyStimulus();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]        = dq[i].size() > 0;
         bus.req_data[i*8 +: 8]  = (dq[i].size() > 0) ? dq[i][0] : 8'h00;
         bus.req_last[i]         = (lq[i].size() > 0) ? lq[i][0] : 1'b0;
      end
      bus.tx_busy = forceBusy || (busyCnt > 0);
      #1;
   endtask

   task automatic tick();
      logic [NREQ-1:0] acc;
      logic [7:0]      prevData;
      logic            prevSend;
      logic            wasRst;
      bit              ok;
      acc      = rst ? '0 : (bus.req_valid & bus.req_ready);
      prevData = bus.tx_data;
      prevSend = bus.tx_send;
      wasRst   = rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) begin
            dq[i].delete(0);
            lq[i].delete(0);
         end
      end
      if (busyCnt > 0) busyCnt--;
      if (startPending) begin
         busyCnt      = frameLen;
         startPending = 1'b0;
      end
      if (bus.tx_send === 1'b1 && !ignoreUart) begin
         rxQ.push_back(bus.tx_data);
         startPending = 1'b1;
      end
      applyStimulus();
      ok = $onehot0(bus.req_ready) && ((bus.req_ready & ~bus.req_valid) == '0)
           && !(prevSend === 1'b1 && bus.tx_send === 1'b1)
           && (wasRst === 1'b1 || acc != '0 || bus.tx_data === prevData);
      checkOutput("protocol", 32'(ok), 32'd1);
   endtask

   function automatic bit isDone();
      bit empty;
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (dq[i].size() > 0) empty = 1'b0;
      return empty && bus.idle === 1'b1 && busyCnt == 0 && !startPending && !forceBusy;
   endfunction

   task automatic runUntilIdle(input string tag, input int maxCycles);
      for (int n = 0; n < maxCycles && !isDone(); n++) tick();
      checkOutput(tag, 32'(isDone()), 32'd1);
   endtask

   task automatic checkRx(input string tag, input byteQ_t exp);
      checkOutput({tag, "_len"}, 32'(rxQ.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size(); i++)
         if (i < rxQ.size()) checkOutput($sformatf("%s[%0d]", tag, i), 32'(rxQ[i]), 32'(exp[i]));
   endtask

   task automatic resetDut();
      for (int i = 0; i < NREQ; i++) begin
         dq[i].delete();
         lq[i].delete();
      end
      rxQ.delete();
      busyCnt      = 0;
      startPending = 1'b0;
      forceBusy    = 1'b0;
      ignoreUart   = 1'b0;
      mPtr         = 0;
      rst = 1'b1;
      applyStimulus();
      tick();
      tick();
      rst = 1'b0;
      applyStimulus();
   endtask

   // Whole messages go out one after another; the pointer moves past a requester only once its message ends.
   task automatic modelOrder(output byteQ_t exp);
      logic [7:0] cd[NREQ][$];
      bit         cl[NREQ][$];
      int         w;
      bit         found;
      bit         l;
      exp.delete();
      for (int i = 0; i < NREQ; i++) begin
         cd[i] = dq[i];
         cl[i] = lq[i];
      end
      for (int guard = 0; guard < 1000; guard++) begin
         found = 1'b0;
         w     = 0;
         for (int k = 0; k < NREQ; k++) begin
            if (!found && cd[(mPtr + k) % NREQ].size() > 0) begin
               found = 1'b1;
               w     = (mPtr + k) % NREQ;
            end
         end
         if (!found) break;
         l = 1'b0;
         while (!l && cd[w].size() > 0) begin
            exp.push_back(cd[w].pop_front());
            l = cl[w].pop_front();
         end
         if (l) mPtr = (w + 1) % NREQ;
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      byteQ_t          e;
      logic [NREQ-1:0] readySeen;
      int              nmsg;
      int              len;

      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      bus.tx_busy   = 1'b0;
      resetDut();

      // Reset values
      checkOutput("rst_tx_send", 32'(bus.tx_send), 32'd0);
      checkOutput("rst_tx_data", 32'(bus.tx_data), 32'h00);
      checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("rst_grant", 32'(bus.grant), 32'h0);
      checkOutput("rst_idle", 32'(bus.idle), 32'd1);

      // Single byte
      pushByte(0, 8'hA5, 1'b1);
      applyStimulus();
      checkOutput("single_ready", 32'(bus.req_ready), 32'h1);
      tick();
      checkOutput("single_send", 32'(bus.tx_send), 32'd1);
      checkOutput("single_data", 32'(bus.tx_data), 32'hA5);
      checkOutput("single_grant", 32'(bus.grant), 32'h1);
      checkOutput("single_idle_low", 32'(bus.idle), 32'd0);
      checkOutput("single_ready_drop", 32'(bus.req_ready), 32'h0);
      tick();
      checkOutput("single_send_pulse", 32'(bus.tx_send), 32'd0);
      runUntilIdle("single_done", 200);
      e = '{8'hA5};
      checkRx("single_rx", e);
      checkOutput("single_grant_clr", 32'(bus.grant), 32'h0);

      // Round robin from pointer 0, then from pointer 2
      resetDut();
      pushByte(0, 8'h10, 1'b1);
      pushByte(1, 8'h21, 1'b1);
      pushByte(2, 8'h32, 1'b1);
      pushByte(3, 8'h43, 1'b1);
      applyStimulus();
      runUntilIdle("rr0_done", 400);
      e = '{8'h10, 8'h21, 8'h32, 8'h43};
      checkRx("rr0", e);
      pushByte(1, 8'h5B, 1'b1);
      applyStimulus();
      runUntilIdle("rrptr_done", 200);
      rxQ.delete();
      pushByte(0, 8'h10, 1'b1);
      pushByte(1, 8'h21, 1'b1);
      pushByte(2, 8'h32, 1'b1);
      pushByte(3, 8'h43, 1'b1);
      applyStimulus();
      runUntilIdle("rr2_done", 400);
      e = '{8'h32, 8'h43, 8'h10, 8'h21};
      checkRx("rr2", e);

      // Message lock with a 50-cycle gap in the owner's valid
      resetDut();
      pushByte(0, 8'h5A, 1'b1);
      applyStimulus();
      runUntilIdle("lock_pre_done", 200);
      rxQ.delete();
      pushByte(1, 8'h11, 1'b0);
      pushByte(0, 8'hEE, 1'b1);
      applyStimulus();
      for (int n = 0; n < 60 && !(rxQ.size() == 1 && busyCnt == 0 && !startPending); n++) tick();
      tick();
      tick();
      readySeen = '0;
      for (int n = 0; n < 50; n++) begin
         tick();
         readySeen |= bus.req_ready;
      end
      checkOutput("lock_gap_ready", 32'(readySeen), 32'h0);
      checkOutput("lock_gap_grant", 32'(bus.grant), 32'h2);
      checkOutput("lock_gap_idle", 32'(bus.idle), 32'd0);
      checkOutput("lock_gap_rx", 32'(rxQ.size()), 32'd1);
      pushByte(1, 8'h22, 1'b0);
      pushByte(1, 8'h33, 1'b1);
      applyStimulus();
      runUntilIdle("lock_done", 400);
      e = '{8'h11, 8'h22, 8'h33, 8'hEE};
      checkRx("lock", e);

      // Busy timeout: uart ignores tx_send
      ignoreUart = 1'b1;
      pushByte(2, 8'h77, 1'b1);
      pushByte(3, 8'h88, 1'b1);
      applyStimulus();
      for (int n = 0; n < 20 && bus.req_ready == '0; n++) tick();
      checkOutput("to_ready", 32'(bus.req_ready), 32'h4);
      tick();
      checkOutput("to_send", 32'(bus.tx_send), 32'd1);
      readySeen = '0;
      for (int n = 0; n < TIMEOUT - 1; n++) begin
         tick();
         readySeen |= bus.req_ready;
      end
      checkOutput("to_wait_ready", 32'(readySeen), 32'h0);
      tick();
      checkOutput("to_reaccept", 32'(bus.req_ready), 32'h8);
      checkOutput("to_idle", 32'(bus.idle), 32'd1);
      runUntilIdle("to_done", 200);
      ignoreUart = 1'b0;

      // External busy holds off the accept until it drops
      rxQ.delete();
      forceBusy = 1'b1;
      pushByte(2, 8'h99, 1'b1);
      applyStimulus();
      readySeen = '0;
      for (int n = 0; n < 5; n++) begin
         tick();
         readySeen |= bus.req_ready;
      end
      checkOutput("xbusy_hold", 32'(readySeen), 32'h0);
      forceBusy = 1'b0;
      applyStimulus();
      checkOutput("xbusy_accept", 32'(bus.req_ready), 32'h4);
      runUntilIdle("xbusy_done", 200);
      e = '{8'h99};
      checkRx("xbusy", e);

      // Reset during WAIT_DONE with the lock held by requester 3
      frameLen = 8;
      rxQ.delete();
      pushByte(3, 8'hC1, 1'b0);
      pushByte(3, 8'hC2, 1'b1);
      pushByte(0, 8'hD0, 1'b1);
      applyStimulus();
      for (int n = 0; n < 20 && !(bus.tx_busy === 1'b1 && bus.tx_send === 1'b0); n++) tick();
      tick();
      checkOutput("mid_owner", 32'(bus.grant), 32'h8);
      rst = 1'b1;
      tick();
      checkOutput("mid_tx_send", 32'(bus.tx_send), 32'd0);
      checkOutput("mid_tx_data", 32'(bus.tx_data), 32'h00);
      checkOutput("mid_grant", 32'(bus.grant), 32'h0);
      checkOutput("mid_idle", 32'(bus.idle), 32'd1);
      checkOutput("mid_ready", 32'(bus.req_ready), 32'h0);
      rst = 1'b0;
      rxQ.delete();
      applyStimulus();
      runUntilIdle("mid_done", 400);
      e = '{8'hD0, 8'hC2};
      checkRx("mid", e);

      // Randomized message mixes against the queue model
      resetDut();
      for (int r = 0; r < 25; r++) begin
         frameLen = $urandom_range(1, 8);
         for (int i = 0; i < NREQ; i++) begin
            nmsg = $urandom_range(0, 2);
            for (int m = 0; m < nmsg; m++) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) pushByte(i, 8'($urandom), b == len - 1);
            end
         end
         modelOrder(e);
         rxQ.delete();
         applyStimulus();
         runUntilIdle($sformatf("rnd%0d_done", r), 3000);
         checkRx($sformatf("rnd%0d", r), e);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
